// File: rtl/sigma_delta_dac_output.sv
// sigma_delta_dac_output
//   First-order sigma-delta (pulse-density) transmitter. Each accepted
//   WIDTH-bit unsigned code D becomes exactly D ones per 2^WIDTH-cycle frame
//   on lvds_out, so a receiver integrating over the same window reads D back.
//
//   Build option: SIGMA_DELTA_DAC_FRAME_ALIGN_EN
//     defined   - codes go through a one-entry holding buffer and are loaded
//                 only at the frame boundary; underrun flags a reused code.
//     undefined - free-running: an accepted code is loaded immediately,
//                 no holding buffer, underrun tied low.
//
// Ports
//   clock          single clock, rising edge
//   reset          synchronous, active-high
//   data_in        unsigned sample code D
//   data_in_valid  data_in holds a sample
//   data_in_ready  block can take a sample (transfer on valid & ready)
//   lvds_out       registered pulse-density bit stream
//   frame_strobe   one-cycle pulse on the first bit of each frame
//   underrun       one-cycle pulse when a frame starts without a new sample
module sigma_delta_dac_output #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic             lvds_out,
    output logic             frame_strobe,
    output logic             underrun
);

    logic [WIDTH-1:0] frame_cnt;
    logic [WIDTH-1:0] active_code;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_sum;
    logic             carry;
    logic             accept;

    // Phase-accumulator step at WIDTH+1 bits; the top bit is the output pulse.
    function automatic logic [WIDTH:0] phase_step(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign {carry, acc_sum} = phase_step(acc, active_code);
    assign accept           = data_in_valid & data_in_ready;

    // Accumulator / output stage: lvds_out lags the accumulator step by one
    // cycle, so the first bit of a frame appears together with frame_strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt    <= '0;
            acc          <= '0;
            lvds_out     <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            frame_cnt    <= frame_cnt + WIDTH'(1);
            acc          <= acc_sum;
            lvds_out     <= carry;
            frame_strobe <= (frame_cnt == '0);
        end
    end

`ifdef SIGMA_DELTA_DAC_FRAME_ALIGN_EN
    logic [WIDTH-1:0] pending;
    logic             pending_valid;
    logic             frame_end;

    assign frame_end     = (frame_cnt == {WIDTH{1'b1}});
    assign data_in_ready = ~pending_valid & ~reset;

    // Load stage: acc is back at zero on every boundary (2^WIDTH additions of a
    // constant wrap it exactly), so swapping the code here needs no clear.
    // An accept cannot coincide with a load because ready is low while the
    // buffer is full.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_valid <= 1'b0;
            active_code   <= '0;
            underrun      <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (frame_end) begin
                if (pending_valid) begin
                    active_code   <= pending;
                    pending_valid <= 1'b0;
                end else begin
                    underrun <= 1'b1;
                end
            end
            if (accept) begin
                pending_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            pending <= data_in;
        end
    end
`else
    assign data_in_ready = ~reset;
    assign underrun      = 1'b0;

    // Free-running load: the code takes effect on the acceptance edge and the
    // accumulator keeps its phase across the change.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_code <= '0;
        end else if (accept) begin
            active_code <= data_in;
        end
    end
`endif

endmodule

// File: tb/tb_sigma_delta_dac_output.sv
// Testbench for sigma_delta_dac_output (WIDTH = 5, 32-cycle frames).
// Works in both builds, selected by SIGMA_DELTA_DAC_FRAME_ALIGN_EN.
module tb_sigma_delta_dac_output;

    localparam int WIDTH = 5;
    localparam int FRAME = 32;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             data_in_valid;
    logic             data_in_ready;
    logic             lvds_out;
    logic             frame_strobe;
    logic             underrun;

    sigma_delta_dac_output #(.WIDTH(WIDTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .lvds_out      (lvds_out),
        .frame_strobe  (frame_strobe),
        .underrun      (underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Bit k (0-based from frame_strobe) of a frame carrying code d.
    function automatic logic sd_bit(input logic [WIDTH-1:0] d, input int k);
        int a;
        int b;
        a = ((k + 1) * int'(d)) / FRAME;
        b = (k * int'(d)) / FRAME;
        return (a != b);
    endfunction

    // Reference model, advanced on every rising edge with pre-edge values.
    logic started = 1'b0;
    int   pos = 0;
    logic exp_lvds = 1'b0;
    logic exp_strobe = 1'b0;
    logic exp_under = 1'b0;
`ifdef SIGMA_DELTA_DAC_FRAME_ALIGN_EN
    logic [WIDTH-1:0] cur = '0;
    logic [WIDTH-1:0] pend_q[$];
`else
    logic             fr_act = 1'b0;
    int               fr_k = 0;
    logic [WIDTH-1:0] fr_code = '0;
`endif

    always @(posedge clock) begin
        if (reset) begin
            started    <= 1'b1;
            pos        <= 0;
            exp_lvds   <= 1'b0;
            exp_strobe <= 1'b0;
            exp_under  <= 1'b0;
`ifdef SIGMA_DELTA_DAC_FRAME_ALIGN_EN
            cur        <= '0;
            pend_q.delete();
`else
            fr_act     <= 1'b0;
            fr_k       <= 0;
`endif
        end else begin
            exp_strobe <= (pos == 0);
            pos        <= (pos + 1) % FRAME;
`ifdef SIGMA_DELTA_DAC_FRAME_ALIGN_EN
            exp_lvds  <= sd_bit(cur, pos);
            exp_under <= (pos == FRAME - 1) && (pend_q.size() == 0);
            if (pos == FRAME - 1 && pend_q.size() != 0) begin
                cur <= pend_q[0];
                void'(pend_q.pop_front());
            end
            if (data_in_valid && data_in_ready) pend_q.push_back(data_in);
`else
            exp_lvds  <= fr_act ? sd_bit(fr_code, fr_k) : 1'b0;
            exp_under <= 1'b0;
            if (fr_act) fr_k <= fr_k + 1;
            if (data_in_valid && data_in_ready) begin
                fr_code <= data_in;
                fr_act  <= 1'b1;
                fr_k    <= 0;
            end
`endif
        end
    end

    // Output checks on the falling edge.
    logic done = 1'b0;
    int   tmo_errs = 0;
`ifdef SIGMA_DELTA_DAC_FRAME_ALIGN_EN
    logic             in_frame = 1'b0;
    int               ones = 0;
    int               nbits = 0;
    int               frames_done = 0;
    logic [WIDTH-1:0] frame_code = '0;
`endif

    always @(negedge clock) begin
        if (started) begin
`ifdef SIGMA_DELTA_DAC_FRAME_ALIGN_EN
            check_eq("ready", int'(data_in_ready), int'(!reset && pend_q.size() == 0));
`else
            check_eq("ready", int'(data_in_ready), int'(!reset));
`endif
            check_eq("strobe", int'(frame_strobe), int'(exp_strobe));
            check_eq("underrun", int'(underrun), int'(exp_under));
            check_eq("lvds", int'(lvds_out), int'(exp_lvds));
`ifdef SIGMA_DELTA_DAC_FRAME_ALIGN_EN
            if (reset) begin
                in_frame <= 1'b0;
            end else if (exp_strobe) begin
                if (in_frame && nbits == FRAME) begin
                    check_eq("frame_ones", ones, int'(frame_code));
                    frames_done <= frames_done + 1;
                end
                in_frame   <= 1'b1;
                frame_code <= cur;
                ones       <= int'(lvds_out);
                nbits      <= 1;
            end else if (in_frame) begin
                ones  <= ones + int'(lvds_out);
                nbits <= nbits + 1;
            end
`endif
            if (done) begin
                check_eq("handshake_timeouts", tmo_errs, 0);
`ifdef SIGMA_DELTA_DAC_FRAME_ALIGN_EN
                check_eq("frames_counted", int'(frames_done >= 10), 1);
`endif
                $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Present d with valid high; returns just after the accepting edge.
    // valid is left high so back-to-back sends model a held valid.
    task automatic send(input logic [WIDTH-1:0] d);
        int n;
        n = 0;
        data_in       = d;
        data_in_valid = 1'b1;
        while (!data_in_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!data_in_ready) tmo_errs++;
        tick(1);
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (pos != p && n < 100) begin
            tick(1);
            n++;
        end
        if (pos != p) tmo_errs++;
    endtask

    initial begin
        reset         = 1'b1;
        data_in       = '0;
        data_in_valid = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(70);
`ifdef SIGMA_DELTA_DAC_FRAME_ALIGN_EN
        send(5'd16); send(5'd16); send(5'd16);
        data_in_valid = 1'b0;
        tick(70);
        send(5'd1); send(5'd31);
        data_in_valid = 1'b0;
        tick(100);
        send(5'd5); send(5'd9); send(5'd20);
        data_in_valid = 1'b0;
        tick(70);
        wait_pos(2);
        send(5'd7);
        data_in_valid = 1'b0;
        wait_pos(10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(80);
`else
        wait_pos(13);
        send(5'd31);
        data_in_valid = 1'b0;
        tick(45);
`endif
        done = 1'b1;
        tick(5);
    end

endmodule
